// File: rtl/gpa_fhdo_dac_model.sv
// GPA-FHDO DAC-side SPI responder: oversampled 24-bit frame decoder driving a
// SYNC/LDAC-controlled four-channel DAC register file with sdo readback.
module gpa_fhdo_dac_model #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [15:0] DEVICE_ID   = 16'h0A14,
   parameter logic [15:0] DAC_RESET   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk_i,
   input  logic        csn_i,
   input  logic        sdi_i,
   input  logic        ldac_i,
   output logic        sdo_o,
   output logic [15:0] dac0_o,
   output logic [15:0] dac1_o,
   output logic [15:0] dac2_o,
   output logic [15:0] dac3_o,
   output logic [3:0]  update_o,
   output logic [15:0] sync_reg_o,
   output logic        frame_err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync;
   logic        sclk_d, csn_d;
   logic        sclk_s, csn_s, sdi_s;
   logic        sclk_rise, sclk_fall, csn_rise, csn_fall;

   logic [4:0]  bit_cnt;
   logic [23:0] shift_in, shift_out, rb_word;
   logic [15:0] buf_q [4];
   logic [15:0] dac_q [4];
   logic [15:0] rd_val;
   logic        frm_rw, chan_wr;
   logic [3:0]  frm_addr;
   logic [15:0] frm_data;
   logic [1:0]  chan;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign sclk_rise = ~sclk_d & sclk_s;
   assign sclk_fall = sclk_d & ~sclk_s;
   assign csn_rise  = ~csn_d & csn_s;
   assign csn_fall  = csn_d & ~csn_s;
   assign busy_o    = ~csn_s;

   assign frm_rw   = shift_in[23];
   assign frm_addr = shift_in[19:16];
   assign frm_data = shift_in[15:0];
   assign chan     = frm_addr[1:0];
   assign chan_wr  = ~frm_rw & (frm_addr[3:2] == 2'b10);

   assign dac0_o = dac_q[0];
   assign dac1_o = dac_q[1];
   assign dac2_o = dac_q[2];
   assign dac3_o = dac_q[3];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         csn_sync  <= '1;
         sdi_sync  <= '0;
         sclk_d    <= 1'b0;
         csn_d     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
         csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_i};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi_i};
         sclk_d    <= sclk_s;
         csn_d     <= csn_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (csn_fall) state_nxt = SHIFT;
         SHIFT:   if (csn_rise) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      case (frm_addr)
         4'h1:                   rd_val = DEVICE_ID;
         4'h2:                   rd_val = sync_reg_o;
         4'h8, 4'h9, 4'hA, 4'hB: rd_val = buf_q[chan];
         default:                rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sdo_o       <= 1'b0;
         update_o    <= '0;
         sync_reg_o  <= 16'hFF00;
         frame_err_o <= 1'b0;
         bit_cnt     <= '0;
         shift_in    <= '0;
         shift_out   <= '0;
         rb_word     <= '0;
         for (int unsigned n = 0; n < 4; n++) begin
            buf_q[n] <= DAC_RESET;
            dac_q[n] <= DAC_RESET;
         end
      end else begin
         update_o    <= '0;
         frame_err_o <= 1'b0;
         for (int unsigned n = 0; n < 4; n++) begin
            if (ldac_i && sync_reg_o[n]) begin
               dac_q[n]    <= buf_q[n];
               update_o[n] <= 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (csn_fall) begin
                  bit_cnt   <= '0;
                  shift_out <= rb_word;
                  sdo_o     <= rb_word[23];
               end
            end
            SHIFT: begin
               if (sclk_fall) begin
                  shift_in <= {shift_in[22:0], sdi_s};
                  if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
               end
               // the rising edge before the first sample keeps bit 23 on sdo
               if (sclk_rise && bit_cnt != 5'd0) begin
                  sdo_o     <= shift_out[22];
                  shift_out <= {shift_out[22:0], 1'b0};
               end
            end
            COMMIT: begin
               if (bit_cnt == 5'd24) begin
                  if (frm_rw) begin
                     rb_word <= {1'b1, 3'b000, frm_addr, rd_val};
                  end else begin
                     rb_word <= '0;
                     if (frm_addr == 4'h2) sync_reg_o <= frm_data;
                     // a coincident ldac must not overwrite this channel with its stale buffer
                     if (chan_wr) begin
                        buf_q[chan] <= frm_data;
                        if (!sync_reg_o[chan] || ldac_i) begin
                           dac_q[chan]    <= frm_data;
                           update_o[chan] <= 1'b1;
                        end
                     end
                  end
               end else begin
                  frame_err_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpa_fhdo_dac_model.sv
// Self-checking bench for gpa_fhdo_dac_model: directed test-plan frames plus
// randomized frames, checked every cycle against a frame-level register model.
module tb_gpa_fhdo_dac_model;
   localparam int unsigned S   = 2;
   localparam int unsigned H   = 6;
   localparam int unsigned GAP = 14;

   logic clk = 1'b0, rst_n = 1'b0, sclk_i = 1'b0, csn_i = 1'b1, sdi_i = 1'b0, ldac_i = 1'b0;
   logic        sdo_o, frame_err_o, busy_o;
   logic [15:0] dac0_o, dac1_o, dac2_o, dac3_o, sync_reg_o;
   logic [3:0]  update_o;

   gpa_fhdo_dac_model #(.SYNC_STAGES(S), .DEVICE_ID(16'h0A14), .DAC_RESET(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .csn_i(csn_i), .sdi_i(sdi_i),
      .ldac_i(ldac_i), .sdo_o(sdo_o), .dac0_o(dac0_o), .dac1_o(dac1_o),
      .dac2_o(dac2_o), .dac3_o(dac3_o), .update_o(update_o), .sync_reg_o(sync_reg_o),
      .frame_err_o(frame_err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      bit          is_ldac;
      int unsigned len;
      logic [23:0] frame;
   } ev_t;
   ev_t evq[$];

   int unsigned cyc = 0;
   logic        rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   logic [15:0] m_dac [4];
   logic [15:0] m_buf [4];
   logic [15:0] m_sync;
   logic [23:0] m_rb;
   logic [3:0]  exp_upd;
   logic        exp_err, exp_sdo;
   bit          chk_en = 1'b0, sdo_chk = 1'b0;
   int          n_checks = 0, n_fail = 0, err_seen = 0;
   logic [23:0] last_sdo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         m_dac[n] = 16'h0000;
         m_buf[n] = 16'h0000;
      end
      m_sync = 16'hFF00;
      m_rb   = '0;
      evq.delete();
   endtask

   function automatic logic [15:0] m_read(input logic [3:0] a);
      if (a == 4'h1) return 16'h0A14;
      if (a == 4'h2) return m_sync;
      if (a >= 4'h8 && a <= 4'hB) return m_buf[a[1:0]];
      return 16'h0000;
   endfunction

   bit          c_ld, c_fr;
   int unsigned c_len;
   logic [23:0] c_f;
   logic [3:0]  c_a;
   logic [15:0] c_d;
   ev_t         c_ev;

   always @(negedge clk) begin
      if (chk_en) begin
         exp_upd = '0;
         exp_err = 1'b0;
         if (!rst_q) begin
            model_reset();
         end else begin
            c_ld = 1'b0; c_fr = 1'b0; c_len = 0; c_f = '0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
               c_ev = evq.pop_front();
               if (c_ev.is_ldac) c_ld = 1'b1;
               else begin c_fr = 1'b1; c_len = c_ev.len; c_f = c_ev.frame; end
            end
            if (c_ld)
               for (int n = 0; n < 4; n++)
                  if (m_sync[n]) begin m_dac[n] = m_buf[n]; exp_upd[n] = 1'b1; end
            if (c_fr) begin
               if (c_len != 24) exp_err = 1'b1;
               else begin
                  c_a = c_f[19:16];
                  c_d = c_f[15:0];
                  if (c_f[23]) m_rb = {1'b1, 3'b000, c_a, m_read(c_a)};
                  else begin
                     m_rb = '0;
                     if (c_a == 4'h2) m_sync = c_d;
                     else if (c_a >= 4'h8 && c_a <= 4'hB) begin
                        m_buf[c_a[1:0]] = c_d;
                        if (!m_sync[c_a[1:0]] || c_ld) begin
                           m_dac[c_a[1:0]] = c_d;
                           exp_upd[c_a[1:0]] = 1'b1;
                        end
                     end
                  end
               end
            end
         end
         check("dac0", 32'(dac0_o), 32'(m_dac[0]));
         check("dac1", 32'(dac1_o), 32'(m_dac[1]));
         check("dac2", 32'(dac2_o), 32'(m_dac[2]));
         check("dac3", 32'(dac3_o), 32'(m_dac[3]));
         check("sync_reg", 32'(sync_reg_o), 32'(m_sync));
         check("update", 32'(update_o), 32'(exp_upd));
         check("frame_err", 32'(frame_err_o), 32'(exp_err));
         if (!rst_q) begin
            check("sdo_reset", 32'(sdo_o), 32'd0);
            check("busy_reset", 32'(busy_o), 32'd0);
         end
         if (sdo_chk) check("sdo", 32'(sdo_o), 32'(exp_sdo));
         if (frame_err_o === 1'b1) err_seen++;
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [63:0] bits, input int unsigned nbits, input int unsigned abort_at);
      logic [23:0] rb, cap;
      ev_t e;
      rb  = m_rb;
      cap = '0;
      csn_i = 1'b0;
      tick(H);
      check("busy_in_frame", 32'(busy_o), 32'd1);
      for (int unsigned i = 0; i < nbits; i++) begin
         if (i == abort_at) begin
            rst_n = 1'b0; csn_i = 1'b1; sclk_i = 1'b0; sdo_chk = 1'b0;
            tick(6);
            rst_n = 1'b1;
            tick(GAP);
            return;
         end
         sdi_i  = bits[nbits-1-i];
         sclk_i = 1'b1;
         tick(4);
         if (i < 24) begin
            exp_sdo = rb[23-i];
            sdo_chk = 1'b1;
            cap     = {cap[22:0], sdo_o};
         end
         tick(H - 4);
         sclk_i = 1'b0;
         tick(H);
         sdo_chk = 1'b0;
      end
      csn_i = 1'b1;
      sdi_i = 1'b0;
      e.cyc = cyc + S + 2; e.is_ldac = 1'b0; e.len = nbits; e.frame = bits[23:0];
      evq.push_back(e);
      last_sdo = cap;
   endtask

   task automatic frame(input logic [23:0] f);
      xfer({40'h0, f}, 24, 999);
      tick(GAP);
   endtask

   task automatic ldac_pulse();
      ev_t e;
      ldac_i = 1'b1;
      e.cyc = cyc + 1; e.is_ldac = 1'b1; e.len = 0; e.frame = '0;
      evq.push_back(e);
      tick(1);
      ldac_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int          e0;
   logic [3:0]  r_addr;
   logic [23:0] r_f;
   int unsigned r_nb;

   initial begin
      tick(4);
      chk_en = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      check("sync_reset", 32'(sync_reg_o), 32'h0000FF00);
      check("dac0_reset", 32'(dac0_o), 32'h0);

      // immediate write, exact strobe latency
      xfer({40'h0, 24'h081234}, 24, 999);
      tick(S + 1);
      check("upd_early", 32'(update_o), 32'h0);
      tick(1);
      check("upd_latency", 32'(update_o), 32'h1);
      check("dac0_1234", 32'(dac0_o), 32'h1234);
      tick(1);
      check("upd_one_cycle", 32'(update_o), 32'h0);
      tick(GAP);
      check("dac1_untouched", 32'(dac1_o), 32'h0);

      frame(24'h020000);
      frame(24'h0AABCD);
      frame(24'h0B00FF);
      check("dac2_abcd", 32'(dac2_o), 32'hABCD);
      check("dac3_00ff", 32'(dac3_o), 32'h00FF);
      check("sync_0000", 32'(sync_reg_o), 32'h0);

      frame(24'h020002);
      frame(24'h095555);
      check("dac1_held", 32'(dac1_o), 32'h0);
      ldac_pulse();
      check("dac1_ldac", 32'(dac1_o), 32'h5555);
      check("upd_ldac", 32'(update_o), 32'h2);
      tick(GAP);

      // coincident ldac and COMMIT on channel 1 with channels 1 and 2 buffered
      frame(24'h020006);
      frame(24'h0A1111);
      check("dac2_buffered", 32'(dac2_o), 32'hABCD);
      xfer({40'h0, 24'h097777}, 24, 999);
      tick(S + 1);
      ldac_pulse();
      check("dac1_commit_wins", 32'(dac1_o), 32'h7777);
      check("dac2_ldac_other", 32'(dac2_o), 32'h1111);
      check("upd_coincident", 32'(update_o), 32'h6);
      tick(GAP);

      frame(24'h810000);
      check("model_rb_id", 32'(m_rb), 32'h810A14);
      frame(24'h000000);
      check("sdo_readback_id", 32'(last_sdo), 32'h810A14);

      e0 = err_seen;
      xfer({40'h0, 24'h0A5A5A}, 23, 999);
      tick(GAP);
      check("err_23bit", 32'(err_seen), 32'(e0 + 1));
      xfer({39'h0, 24'h0A5A5A, 1'b1}, 25, 999);
      tick(GAP);
      check("err_25bit", 32'(err_seen), 32'(e0 + 2));
      check("dac0_after_err", 32'(dac0_o), 32'h1234);
      frame(24'h001357);
      frame(24'h020000);
      frame(24'h081357);
      check("dac0_after_err_frame", 32'(dac0_o), 32'h1357);

      e0 = err_seen;
      xfer({40'h0, 24'h08FFFF}, 24, 10);
      check("dac0_abort", 32'(dac0_o), 32'h0);
      check("sync_abort", 32'(sync_reg_o), 32'h0000FF00);
      check("no_err_abort", 32'(err_seen), 32'(e0));
      frame(24'h084321);
      check("dac0_post_abort", 32'(dac0_o), 32'h4321);
      check("busy_idle", 32'(busy_o), 32'h0);

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            ldac_pulse();
            tick(3);
         end
         case ($urandom_range(0, 6))
            0:       r_addr = 4'h1;
            1:       r_addr = 4'h2;
            2:       r_addr = 4'h8;
            3:       r_addr = 4'h9;
            4:       r_addr = 4'hA;
            5:       r_addr = 4'hB;
            default: r_addr = 4'($urandom_range(0, 15));
         endcase
         r_f = {($urandom_range(0, 3) == 0), 3'($urandom), r_addr, 16'($urandom)};
         case ($urandom_range(0, 9))
            0:       r_nb = 23;
            1:       r_nb = 25;
            2:       r_nb = 33;
            default: r_nb = 24;
         endcase
         xfer({24'($urandom), 16'($urandom), r_f}, r_nb, 999);
         tick(GAP);
      end

      tick(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
